counter_tap_led_sequencer: RTL

- Consumer stage placed directly downstream of the shared 27-bit free-running board counter.
- Selects one counter bit as a programmable time base and converts its rising edge into a single-cycle tick.
- Each tick advances an LED pattern state machine: rotate left, rotate right, bounce, or binary count.
- Drives the board LED bank and emits a wrap pulse each time a pattern completes one period.

---
 rtl/counter_tap_led_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/counter_tap_led_sequencer.sv
// counter_tap_led_sequencer: picks one bit of the upstream free-running counter as a time base,
// turns its rising edge into a one-cycle tick, and advances an LED pattern on each tick.
// Patterns: rotate left, rotate right, bounce, binary count. wrap pulses once per period.
// Optional build macro LED_PWM_DIM_EN: gates the LED bank with a registered PWM enable
// derived from counter[3:0] < duty. Without it, duty is ignored.
module counter_tap_led_sequencer #(
    parameter int unsigned LED_W = 8,
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] counter,
    input  logic [4:0]       tap_sel,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [3:0]       duty,
    output logic             tick,
    output logic             wrap,
    output logic [LED_W-1:0] leds
);

    localparam int unsigned IDX_W = $clog2(CNT_W);

    typedef enum logic {StIdle, StRun} seq_state_e;
    typedef enum logic {DirLeft, DirRight} dir_e;

    localparam logic [1:0] ModeRotL   = 2'd0;
    localparam logic [1:0] ModeRotR   = 2'd1;
    localparam logic [1:0] ModeBounce = 2'd2;
    localparam logic [1:0] ModeCount  = 2'd3;

    // ------------------------------------------------------------------
    // Time base: tap selection, edge detection, tick generation
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_q;
    logic             tap_bit;
    logic             tap_q;
    logic             tap_chg;
    logic             suppress_q;
    logic             tick_d;
    logic             tick_q;

    // Clamp the tap index to the top counter bit and detect a tap change.
    always_comb begin
        if (32'(tap_sel) > CNT_W - 1) begin
            idx = IDX_W'(CNT_W - 1);
        end else begin
            idx = IDX_W'(tap_sel);
        end
        tap_bit = counter[idx];
        tap_chg = (idx != idx_q);
    end

    // Rising edge of the tapped bit; a tap change masks the edge it would fake
    // (tap_q still holds the old bit) and the cycle after it.
    always_comb begin
        tick_d = tap_bit & ~tap_q & ~suppress_q & ~tap_chg;
    end

    // Tap history, suppress flag and registered tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            tap_q      <= 1'b0;
            suppress_q <= 1'b1;
            tick_q     <= 1'b0;
        end else begin
            idx_q      <= idx;
            tap_q      <= tap_bit;
            suppress_q <= tap_chg;
            tick_q     <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Pattern sequencer
    // ------------------------------------------------------------------
    seq_state_e       seq_st;
    logic [LED_W-1:0] pattern_q;
    logic [LED_W-1:0] pattern_d;
    dir_e             dir_q;
    dir_e             dir_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic             wrap_q;
    logic             wrap_d;

    function automatic logic is_onehot(input logic [LED_W-1:0] p);
        return (p != '0) && ((p & (p - LED_W'(1))) == '0);
    endfunction

    // RUN/IDLE follows enable with no added latency.
    always_comb begin
        seq_st = enable ? StRun : StIdle;
    end

    // Next pattern, direction, latched mode and wrap for the tick-closing edge.
    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        wrap_d    = 1'b0;
        if (seq_st == StRun && tick_q) begin
            if (mode != mode_q) begin
                // A new mode restarts from its start pattern rather than stepping.
                mode_d    = mode;
                pattern_d = (mode == ModeCount) ? '0 : LED_W'(1);
                dir_d     = DirLeft;
            end else begin
                unique case (mode_q)
                    ModeRotL: begin
                        pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
                        wrap_d    = pattern_q[LED_W-1];
                    end
                    ModeRotR: begin
                        pattern_d = {pattern_q[0], pattern_q[LED_W-1:1]};
                        wrap_d    = pattern_q[0];
                    end
                    ModeBounce: begin
                        if (!is_onehot(pattern_q)) begin
                            pattern_d = LED_W'(1);
                            dir_d     = DirLeft;
                        end else if (dir_q == DirLeft) begin
                            if (pattern_q[LED_W-1]) begin
                                dir_d     = DirRight;
                                pattern_d = pattern_q >> 1;
                            end else begin
                                pattern_d = pattern_q << 1;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                // Leaving bit 0 closes one bounce period.
                                dir_d     = DirLeft;
                                pattern_d = pattern_q << 1;
                                wrap_d    = 1'b1;
                            end else begin
                                pattern_d = pattern_q >> 1;
                            end
                        end
                    end
                    ModeCount: begin
                        pattern_d = pattern_q + LED_W'(1);
                        wrap_d    = &pattern_q;
                    end
                    default: begin
                        pattern_d = pattern_q;
                    end
                endcase
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= LED_W'(1);
            dir_q     <= DirLeft;
            mode_q    <= ModeRotL;
            wrap_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            wrap_q    <= wrap_d;
        end
    end

    assign tick = tick_q;
    assign wrap = wrap_q;

`ifdef LED_PWM_DIM_EN
    logic pwm_q;

    // PWM enable from the low counter nibble; one cycle of latency on leds only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (counter[3:0] < duty);
        end
    end

    assign leds = pattern_q & {LED_W{pwm_q}};
`else
    logic unused_duty;
    assign unused_duty = ^duty;
    assign leds        = pattern_q;
`endif

endmodule
